// File: rtl/uart_tx_frame_if.sv
// Byte handshake and serial-line bundle between a UART transmit client and uart_tx_frame.
interface uart_tx_frame_if;
    logic [7:0] data_in;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       busy;

    modport master (output data_in, output valid, input ready, input tx, input busy);
    modport slave  (input data_in, input valid, output ready, output tx, output busy);
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, 8 data bits LSB first, optional even parity, stop; idle-high line.
// Define UART_TX_PARITY_EN for 8E1 framing; leave it undefined for 8N1.
module uart_tx_frame #(
    parameter int CLK_FREQ = 50000,
    parameter int BAUDRATE = 10000
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_frame_if.slave  bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic              tx_r;
    logic              ready_r;
    logic              busy_r;
    logic              bit_done;
`ifdef UART_TX_PARITY_EN
    logic              parity;
`endif

    assign bit_done  = (baud_cnt == BAUD_LAST);
    assign bus.tx    = tx_r;
    assign bus.ready = ready_r;
    assign bus.busy  = busy_r;

    // tx is always loaded with the value of the bit being entered, so the line is registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_r     <= 1'b1;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else if (state == IDLE) begin
            baud_cnt <= '0;
            if (bus.valid && ready_r) begin
                shift   <= bus.data_in;
`ifdef UART_TX_PARITY_EN
                parity  <= ^bus.data_in;
`endif
                bit_idx <= '0;
                state   <= START;
                tx_r    <= 1'b0;
                ready_r <= 1'b0;
                busy_r  <= 1'b1;
            end
        end else begin
            baud_cnt <= bit_done ? '0 : baud_cnt + BAUD_W'(1);
            if (bit_done) begin
                case (state)
                    START: begin
                        state <= DATA;
                        tx_r  <= shift[0];
                    end
                    DATA: begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx_r  <= parity;
`else
                            state <= STOP;
                            tx_r  <= 1'b1;
`endif
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            tx_r    <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        state <= STOP;
                        tx_r  <= 1'b1;
                    end
`endif
                    STOP: begin
                        state   <= IDLE;
                        tx_r    <= 1'b1;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        tx_r    <= 1'b1;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
